// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic inter-stage pipeline registers.
// State encoding doubles as the occupancy count (EMPTY=0, ONE=1, FULL=2).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // MIPS sll $0,$0,0 -- bubble payload for IF/ID instances.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: count advances by one on each cycle with inc high, sticks at all-ones.
// Latency 1 cycle from inc to count; no backpressure, synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register (PC + payload): valid/ready, optional 2-entry skid, flush-to-bubble.
// Latency 1 cycle; SKID=1 gives a registered in_ready (low only when FULL), SKID=0 a combinational one.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
  parameter bit                SKID     = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state, state_nxt;
  logic              accept, drain;
  logic              load_main_in, load_main_skid, load_skid;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [DATA_W-1:0] main_data, skid_data;

  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign occupancy = state;

  if (SKID) begin : g_skid
    assign in_ready = (state != ST_FULL);
  end else begin : g_noskid
    // Without a skid slot, a slot frees up only when the head leaves on this same edge.
    assign in_ready = !out_valid || out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Squash wins over any accept; a same-edge drain has already been captured downstream.
    if (flush) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_pc   <= '0;
      main_data <= '0;
      skid_pc   <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_pc   <= in_pc;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_pc   <= skid_pc;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_pc   <= in_pc;
        skid_data <= in_data;
      end
    end
  end

  assign out_pc   = out_valid ? main_pc   : {PC_W{1'b0}};
  assign out_data = out_valid ? main_data : NOP_WORD;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a SKID=1/CNT_W=3 instance (a_*) and a SKID=0 instance with a non-zero bubble word (b_*).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] B_NOP = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_pc, a_in_data, a_out_pc, a_out_data;
  logic [1:0]  a_occupancy;
  logic [2:0]  a_stall_cnt;

  logic        b_rst, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_pc, b_in_data, b_out_pc, b_out_data;
  logic [1:0]  b_occupancy;
  logic [15:0] b_stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_stage_reg #(
    .DATA_W(32), .PC_W(32), .NOP_WORD(NOP_INSTR), .SKID(1'b1), .CNT_W(3)
  ) u_dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_pc(a_in_pc), .in_data(a_in_data), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .out_data(a_out_data), .occupancy(a_occupancy), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_reg #(
    .DATA_W(32), .PC_W(32), .NOP_WORD(B_NOP), .SKID(1'b0), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_data(b_in_data), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_data(b_out_data), .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [31:0] pc, input logic [31:0] data);
    a_in_valid = 1'b1;
    a_in_pc    = pc;
    a_in_data  = data;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_out_ready = 1'b0;
    a_push(32'h40, 32'h8C01_0004);
    b_rst = 1'b1; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_pc = 32'h40; b_in_data = 32'h8C01_0004;

    // Reset held two cycles with a valid input pending.
    tick(); tick();
    a_rst = 1'b0; a_in_valid = 1'b0;
    #1;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_data",  a_out_data,  32'h0);
    chk("rst_out_pc",    a_out_pc,    32'h0);
    chk("rst_occ",       a_occupancy, 2'd0);
    chk("rst_in_ready",  a_in_ready,  1'b1);
    chk("rst_stall",     a_stall_cnt, 3'd0);

    // Streaming with downstream always ready.
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_push(32'(4 * i), 32'hA0 + 32'(i));
      tick();
      chk("stream_valid", a_out_valid, 1'b1);
      chk("stream_pc",    a_out_pc,    32'(4 * i));
      chk("stream_data",  a_out_data,  32'hA0 + 32'(i));
      chk("stream_occ",   a_occupancy, 2'd1);
      chk("stream_rdy",   a_in_ready,  1'b1);
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_empty", a_out_valid, 1'b0);
    chk("stream_stall", a_stall_cnt, 3'd0);

    // Skid fill with downstream stalled, then drain.
    a_out_ready = 1'b0;
    a_push(32'h10, 32'h11);
    tick();
    chk("skid1_occ", a_occupancy, 2'd1);
    chk("skid1_rdy", a_in_ready,  1'b1);
    a_push(32'h14, 32'h22);
    tick();
    a_in_valid = 1'b0;
    chk("skid2_occ",   a_occupancy, 2'd2);
    chk("skid2_rdy",   a_in_ready,  1'b0);
    chk("skid2_pc",    a_out_pc,    32'h10);
    chk("skid2_data",  a_out_data,  32'h11);
    chk("skid2_stall", a_stall_cnt, 3'd1);
    tick();
    chk("skid3_pc",    a_out_pc,    32'h10);
    chk("skid3_stall", a_stall_cnt, 3'd2);
    a_out_ready = 1'b1;
    #1;
    chk("skid_rdy_reg", a_in_ready, 1'b0);
    tick();
    chk("drain1_pc",    a_out_pc,    32'h14);
    chk("drain1_data",  a_out_data,  32'h22);
    chk("drain1_occ",   a_occupancy, 2'd1);
    chk("drain1_rdy",   a_in_ready,  1'b1);
    chk("drain1_stall", a_stall_cnt, 3'd2);
    tick();
    chk("drain2_valid", a_out_valid, 1'b0);
    chk("drain2_pc",    a_out_pc,    32'h0);
    chk("drain2_occ",   a_occupancy, 2'd0);

    // Flush while FULL with a simultaneous accept and drain.
    a_out_ready = 1'b0;
    a_push(32'h20, 32'h33);
    tick();
    a_push(32'h24, 32'h44);
    tick();
    chk("fl_full_occ", a_occupancy, 2'd2);
    a_flush = 1'b1; a_out_ready = 1'b1;
    a_push(32'h30, 32'h55);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 1'b0);
    chk("fl_data",  a_out_data,  32'h0);
    chk("fl_pc",    a_out_pc,    32'h0);
    chk("fl_occ",   a_occupancy, 2'd0);
    chk("fl_stall", a_stall_cnt, 3'd3);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fl_no_0x30", a_out_valid, 1'b0);
    end

    // Saturation of the 3-bit stall counter.
    a_out_ready = 1'b0;
    a_push(32'h50, 32'h66);
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt",  a_stall_cnt, 3'd7);
    chk("sat_pc",   a_out_pc,    32'h50);
    chk("sat_data", a_out_data,  32'h66);
    tick(); tick();
    chk("sat_hold", a_stall_cnt, 3'd7);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("sat_flush_cnt",   a_stall_cnt, 3'd7);
    chk("sat_flush_valid", a_out_valid, 1'b0);
    a_rst = 1'b1; a_flush = 1'b1;
    tick();
    a_rst = 1'b0; a_flush = 1'b0;
    chk("sat_rst_cnt", a_stall_cnt, 3'd0);

    // SKID=0 instance: combinational in_ready and same-edge replacement.
    b_rst = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("b_rst_data", b_out_data,  B_NOP);
    chk("b_rst_occ",  b_occupancy, 2'd0);
    chk("b_rst_rdy",  b_in_ready,  1'b1);
    b_in_valid = 1'b1; b_in_pc = 32'h100; b_in_data = 32'h1;
    tick();
    chk("b_one_pc", b_out_pc, 32'h100);
    b_in_pc = 32'h104; b_in_data = 32'h2;
    #1;
    chk("b_rdy_low", b_in_ready, 1'b0);
    tick();
    chk("b_hold_pc",  b_out_pc,    32'h100);
    chk("b_hold_occ", b_occupancy, 2'd1);
    b_out_ready = 1'b1;
    #1;
    chk("b_rdy_comb", b_in_ready, 1'b1);
    tick();
    b_in_valid = 1'b0;
    chk("b_repl_pc",   b_out_pc,    32'h104);
    chk("b_repl_data", b_out_data,  32'h2);
    chk("b_repl_occ",  b_occupancy, 2'd1);
    tick();
    chk("b_empty_valid", b_out_valid, 1'b0);
    chk("b_empty_data",  b_out_data,  B_NOP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register for any inter-stage boundary of the pipelined core (IF/ID, ID/EX, ...). It carries a PC and a payload word (instruction or bundled control/data).
- Provides a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush that squashes to a NOP bubble, and a saturating stall-cycle counter for performance debug.
- Supersedes the fixed 32-bit stall/flush IF/ID latch.

Parameters:
- DATA_W, 32, payload width in bits.
- PC_W, 32, PC width in bits.
- NOP_WORD, {DATA_W{1'b0}}, payload presented on out_data whenever out_valid=0.
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid PC/payload.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  PC_W  upstream PC.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  squash all held entries (branch/jump redirect).
- out_valid  out  1  out_pc/out_data valid.
- out_ready  in  1  downstream accepts (equivalent to !stall).
- out_pc  out  PC_W  head-entry PC; 0 when out_valid=0.
- out_data  out  DATA_W  head-entry payload; NOP_WORD when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready.

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst). On reset: state EMPTY, out_valid=0, out_pc=0, out_data=NOP_WORD, occupancy=0, stall_cnt=0. in_ready=1 in the first cycle after reset. Reset overrides flush and all handshakes.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready. Both are evaluated on the same edge.
- Latency: an accepted entry appears on out_* the next cycle (1 cycle) when the stage was empty or draining.
- Storage: main register (head, drives outputs) and skid register (SKID=1 only).
- FSM for SKID=1; in_ready = (state != FULL), registered from state.
  - EMPTY: accept -> ONE (main <= input).
  - ONE, accept and drain -> ONE (main <= input).
  - ONE, accept and no drain -> FULL (skid <= input).
  - ONE, drain and no accept -> EMPTY.
  - ONE, neither -> ONE (hold).
  - FULL: drain -> ONE (main <= skid). No accept is possible in FULL.
- SKID=0: states EMPTY/ONE only; in_ready = !out_valid || out_ready (combinational); accept with drain replaces main in the same edge.
- Flush (no reset): next state EMPTY; main/skid valid bits cleared; any same-cycle accept is discarded. A same-cycle drain is still a completed transfer, because downstream captured the head. Outputs return to NOP_WORD/0 the next cycle.
- Ordering: strict FIFO. Skid data never bypasses main.
- Held data is stable: out_pc/out_data do not change while out_valid && !out_ready, except on flush.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready and saturates at 2^CNT_W-1. Only rst clears it; flush does not.
- occupancy tracks state: EMPTY=0, ONE=1, FULL=2.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} pipe_state_t
  - localparam NOP_INSTR = 32'h0000_0000 (MIPS sll $0,$0,0), used as the default NOP_WORD for IF/ID instances.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, count) for stall_cnt.
- The FSM and data registers stay in pipe_stage_reg.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_pc=0x40, in_data=0x8C010004 -> after release out_valid=0, out_data=0, out_pc=0, occupancy=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, push PCs 0x00,0x04,0x08 with data 0xA0..0xA2 back-to-back -> each appears exactly 1 cycle later, in order; occupancy stays at 1; in_ready stays 1.
- Skid fill/drain (SKID=1): out_ready=0, push 0x10/0x11 then 0x14/0x22 -> occupancy 2, in_ready=0, out holds 0x10/0x11, stall_cnt increments each cycle. Raise out_ready -> 0x10, then 0x14 drain on consecutive cycles; in_ready=1 one cycle after the first drain.
- Flush with simultaneous accept: state FULL, then flush=1 with in_valid=1 (pc 0x30), out_ready=1 -> head counted as transferred; next cycle out_valid=0, out_data=NOP_WORD, occupancy=0; 0x30 never appears.
- SKID=0 instance: out_ready=0 with one entry held -> in_ready=0 combinationally. Set out_ready=1 and in_valid=1 in the same cycle -> in_ready=1, and the new entry replaces the old on that edge.
- Saturation (CNT_W=3): hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reads 7 and stays at 7; flush leaves it at 7; rst clears it to 0.
